// File: rtl/ysyx_24070016_wbu_if.sv
// ysyx_24070016_wbu_if
//   EXU -> WBU result handshake bundle.
//   master : EXU side, drives valid/pc/rd/wen/result, observes ready
//   slave  : WBU side, observes the result fields, drives ready
//   valid  : EXU presents a result
//   ready  : WBU can accept (buffer not full)
//   pc     : pc of the producing instruction
//   rd     : destination register index
//   wen    : 1 = write rd, 0 = retire without a GPR write
//   result : value to write back
interface ysyx_24070016_wbu_if #(
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [31:0]       pc;
  logic [ADDR_W-1:0] rd;
  logic              wen;
  logic [31:0]       result;

  modport master (output valid, pc, rd, wen, result, input ready);
  modport slave  (input valid, pc, rd, wen, result, output ready);
endinterface

// File: rtl/ysyx_24070016_wbu.sv
// ysyx_24070016_wbu
//   Write-back unit. Buffers up to DEPTH EXU results in a FIFO, retires one
//   per cycle into the GPR file (unless wb_stall), serves two combinational
//   GPR read ports and emits a registered one-cycle commit record per
//   retired entry plus a running retire count.
// Ports
//   clk, rst_n         clock / synchronous active-low reset
//   exu (slave)        valid/ready result handshake {pc, rd, wen, result}
//   wb_stall           hold retirement this cycle
//   rs1_addr/rs1_data  read port 1 (combinational)
//   rs2_addr/rs2_data  read port 2 (combinational)
//   commit_valid/pc/rd/data  registered record of the entry retired last edge
//   commit_cnt         entries retired since reset (wraps)
// Build option
//   WBU_BYPASS_EN : read ports forward the youngest buffered matching result
//                   ahead of the GPR file; without it reads see GPRs only.
module ysyx_24070016_wbu #(
  parameter int NR_REGS = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ysyx_24070016_wbu_if.slave   exu,
  input  logic                 wb_stall,
  input  logic [ADDR_W-1:0]    rs1_addr,
  output logic [31:0]          rs1_data,
  input  logic [ADDR_W-1:0]    rs2_addr,
  output logic [31:0]          rs2_data,
  output logic                 commit_valid,
  output logic [31:0]          commit_pc,
  output logic [ADDR_W-1:0]    commit_rd,
  output logic [31:0]          commit_data,
  output logic [CNT_W-1:0]     commit_cnt
);
  localparam int NSLOT  = 1 << ADDR_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BW = $clog2(DEPTH + 1);

  // reg_ok[a]: index a names a real, writable GPR (not x0, below NR_REGS)
  logic [NSLOT-1:0] reg_ok;
  for (genvar g = 0; g < NSLOT; g++) begin : g_ok
    assign reg_ok[g] = (g != 0) && (g < NR_REGS);
  end

  logic [31:0]       gpr     [NSLOT];
  logic [31:0]       buf_pc  [DEPTH];
  logic [ADDR_W-1:0] buf_rd  [DEPTH];
  logic              buf_wen [DEPTH];
  logic [31:0]       buf_res [DEPTH];

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_BW-1:0] count;

  logic do_push, do_pop, head_wr;

  // ready deliberately ignores a same-cycle pop: full means full
  assign exu.ready = (count != CNT_BW'(DEPTH));
  assign do_push   = exu.valid && exu.ready;
  assign do_pop    = (count != '0) && !wb_stall;
  assign head_wr   = buf_wen[head] && reg_ok[buf_rd[head]];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      buf_pc[tail]  <= exu.pc;
      buf_rd[tail]  <= exu.rd;
      buf_wen[tail] <= exu.wen;
      buf_res[tail] <= exu.result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_rd    <= '0;
      commit_data  <= '0;
      commit_cnt   <= '0;
      for (int i = 0; i < NSLOT; i++) gpr[i] <= '0;
    end else begin
      if (do_push) tail <= ptr_inc(tail);
      if (do_pop)  head <= ptr_inc(head);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;

      commit_valid <= do_pop;
      if (do_pop) begin
        if (head_wr) gpr[buf_rd[head]] <= buf_res[head];
        commit_pc   <= buf_pc[head];
        commit_rd   <= buf_wen[head] ? buf_rd[head] : '0;
        commit_data <= head_wr ? buf_res[head] : '0;
        commit_cnt  <= commit_cnt + 1'b1;
      end
    end
  end

  function automatic logic [31:0] read_port(input logic [ADDR_W-1:0] a);
    logic [31:0] d;
    d = reg_ok[a] ? gpr[a] : '0;
`ifdef WBU_BYPASS_EN
    // Walk oldest -> youngest so the youngest match wins; the head entry
    // stays visible during the cycle it retires.
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W:0]   s;
      logic [PTR_W-1:0] idx;
      s = {1'b0, head} + (PTR_W+1)'(i);
      if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
      idx = s[PTR_W-1:0];
      if ((CNT_BW'(i) < count) && buf_wen[idx] && (buf_rd[idx] == a) && reg_ok[a])
        d = buf_res[idx];
    end
`endif
    return d;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end
endmodule

// File: tb/tb_ysyx_24070016_wbu.sv
module tb_ysyx_24070016_wbu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_stall;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [31:0] commit_cnt;

  ysyx_24070016_wbu_if #(.ADDR_W(5)) exu_bus ();

  ysyx_24070016_wbu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exu          (exu_bus),
    .wb_stall     (wb_stall),
    .rs1_addr     (rs1_addr),
    .rs1_data     (rs1_data),
    .rs2_addr     (rs2_addr),
    .rs2_data     (rs2_data),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .commit_cnt   (commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } commit_t;

  commit_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every commit pulse is matched against the oldest
  // expected entry, sampled on the falling edge.
  always @(negedge clk) begin
    if (commit_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", 64'(commit_valid), 64'd0);
      end else begin
        commit_t e;
        e = sb.pop_front();
        exp_cnt = exp_cnt + 1;
        check("commit_pc",   64'(commit_pc),   64'(e.pc));
        check("commit_rd",   64'(commit_rd),   64'(e.rd));
        check("commit_data", 64'(commit_data), 64'(e.data));
        check("commit_cnt",  64'(commit_cnt),  64'(exp_cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one result for one edge; the bench states whether it must be taken.
  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                      input logic [31:0] res, input logic accept);
    commit_t e;
    exu_bus.valid  = 1'b1;
    exu_bus.pc     = pc;
    exu_bus.rd     = rd;
    exu_bus.wen    = wen;
    exu_bus.result = res;
    check("ready_before_push", 64'(exu_bus.ready), 64'(accept));
    if (accept) begin
      e.pc   = pc;
      e.rd   = wen ? rd : 5'd0;
      e.data = (wen && rd != 0) ? res : 32'd0;
      sb.push_back(e);
    end
    tick();
    exu_bus.valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wb_stall = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd0;
    exu_bus.valid = 1'b0; exu_bus.pc = '0; exu_bus.rd = '0;
    exu_bus.wen = 1'b0; exu_bus.result = '0;
    #2;
    tick();
    // reset state
    check("rst_rs1", 64'(rs1_data), 64'd0);
    check("rst_ready", 64'(exu_bus.ready), 64'd1);
    check("rst_cnt", 64'(commit_cnt), 64'd0);
    check("rst_cvalid", 64'(commit_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // basic write of x5
    push(32'h8000_0000, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    rs1_addr = 5'd5;
    #1;
    check("basic_rs1", 64'(rs1_data), 64'hDEAD_BEEF);
    check("basic_cnt", 64'(commit_cnt), 64'd1);

    // x0 stays zero, still retired and counted
    push(32'h8000_0004, 5'd0, 1'b1, 32'h0000_1234, 1'b1);
    tick();
    rs2_addr = 5'd0;
    #1;
    check("x0_rs2", 64'(rs2_data), 64'd0);
    check("x0_cnt", 64'(commit_cnt), 64'd2);

    // wen=0 retires without touching x3
    push(32'h8000_0008, 5'd3, 1'b0, 32'h0000_0055, 1'b1);
    tick();
    rs2_addr = 5'd3;
    #1;
    check("nowen_rs2", 64'(rs2_data), 64'd0);

    // full / stall: two fill the buffer, the third is refused
    wb_stall = 1'b1;
    push(32'h8000_0010, 5'd10, 1'b1, 32'h0000_000A, 1'b1);
    push(32'h8000_0014, 5'd11, 1'b1, 32'h0000_000B, 1'b1);
    check("full_ready", 64'(exu_bus.ready), 64'd0);
    push(32'h8000_0018, 5'd12, 1'b1, 32'h0000_000C, 1'b0);
    check("full_cvalid", 64'(commit_valid), 64'd0);
    wb_stall = 1'b0;
    tick();
    check("ready_after_pop", 64'(exu_bus.ready), 64'd1);
    tick();
    tick();
    rs1_addr = 5'd10; rs2_addr = 5'd11;
    #1;
    check("full_rs1", 64'(rs1_data), 64'h0000_000A);
    check("full_rs2", 64'(rs2_data), 64'h0000_000B);
    rs2_addr = 5'd12;
    #1;
    check("refused_rs2", 64'(rs2_data), 64'd0);
    check("drain_cvalid", 64'(commit_valid), 64'd0);

    // pending writes to x7: bypass sees youngest, plain build sees the GPR
    wb_stall = 1'b1;
    push(32'h8000_0020, 5'd7, 1'b1, 32'd1, 1'b1);
    push(32'h8000_0024, 5'd7, 1'b1, 32'd2, 1'b1);
    rs1_addr = 5'd7;
    #1;
`ifdef WBU_BYPASS_EN
    check("byp_pending", 64'(rs1_data), 64'd2);
`else
    check("byp_pending", 64'(rs1_data), 64'd0);
`endif
    wb_stall = 1'b0;
    tick();
`ifdef WBU_BYPASS_EN
    check("byp_half", 64'(rs1_data), 64'd2);
`else
    check("byp_half", 64'(rs1_data), 64'd1);
`endif
    tick();
    check("byp_done", 64'(rs1_data), 64'd2);
    tick();

    // back-to-back pushes with same-cycle pops, pointers wrap
    for (int i = 0; i < 5; i++)
      push(32'h8000_0100 + 32'(4 * i), 5'(20 + i), 1'b1, 32'h1000 + 32'(i), 1'b1);
    tick();
    tick();
    rs1_addr = 5'd20; rs2_addr = 5'd24;
    #1;
    check("stream_rs1", 64'(rs1_data), 64'h1000);
    check("stream_rs2", 64'(rs2_data), 64'h1004);

    // reset with two entries buffered: discarded, nothing commits
    wb_stall = 1'b1;
    push(32'h8000_0200, 5'd12, 1'b1, 32'h77, 1'b1);
    push(32'h8000_0204, 5'd13, 1'b1, 32'h88, 1'b1);
    rst_n = 1'b0;
    wb_stall = 1'b0;
    sb.delete();
    exp_cnt = 0;
    tick();
    rst_n = 1'b1;
    rs1_addr = 5'd12; rs2_addr = 5'd5;
    #1;
    check("rst2_ready", 64'(exu_bus.ready), 64'd1);
    check("rst2_cvalid", 64'(commit_valid), 64'd0);
    check("rst2_cnt", 64'(commit_cnt), 64'd0);
    check("rst2_rs2", 64'(rs2_data), 64'd0);
    tick();
    tick();
    check("rst2_rs1", 64'(rs1_data), 64'd0);
    check("rst2_idle", 64'(commit_valid), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
